// File: rtl/ram_copy_engine.sv
// Block copy / block fill initiator for a single-port word RAM with combinational read.
// Copy alternates one READ and one WRITE cycle per word; fill writes one word per cycle.
module ram_copy_engine #(
    parameter int AW = 14,
    parameter int DW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW:0]   len,
    input  logic [DW-1:0] fill_value,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_in,
    output logic          mem_load,
    input  logic [DW-1:0] mem_out,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] fill_q, fill_d;
    logic [DW-1:0] data_q, data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          load_q, load_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] in_q, in_d;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        src_d   = src_q;
        dst_d   = dst_q;
        count_d = count_q;
        fill_d  = fill_q;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    src_d   = src;
                    dst_d   = dst;
                    count_d = len;
                    fill_d  = fill_value;
                    if (len == '0) begin
                        state_d = S_DONE;
                    end else if (mode) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                data_d  = mem_out;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                dst_d   = dst_q + AW'(1);
                count_d = count_q - (AW+1)'(1);
                if (!mode_q) begin
                    src_d = src_q + AW'(1);
                end
                if (count_q == (AW+1)'(1)) begin
                    state_d = S_DONE;
                end else if (mode_q) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered: decode them from the state being entered.
        busy_d = (state_d == S_READ) || (state_d == S_WRITE);
        done_d = (state_d == S_DONE);
        load_d = (state_d == S_WRITE);
        addr_d = '0;
        in_d   = '0;
        if (state_d == S_READ) begin
            addr_d = src_d;
        end else if (state_d == S_WRITE) begin
            addr_d = dst_d;
            in_d   = mode_d ? fill_d : data_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            count_q <= '0;
            fill_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            load_q  <= 1'b0;
            addr_q  <= '0;
            in_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            count_q <= count_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            load_q  <= load_d;
            addr_q  <= addr_d;
            in_q    <= in_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_load    = load_q;
    assign mem_address = addr_q;
    assign mem_in      = in_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ram_copy_engine.sv
// Bench for ram_copy_engine: RAM model, transfer-level reference, per-cycle compare.
module tb_ram_copy_engine;
    localparam int AW    = 14;
    localparam int DW    = 16;
    localparam int MEMSZ = 1 << AW;
    localparam int MASK  = MEMSZ - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] src = '0;
    logic [AW-1:0] dst = '0;
    logic [AW:0]   len = '0;
    logic [DW-1:0] fill_value = '0;
    logic          busy, done, mem_load;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_in, mem_out;
    logic [1:0]    dbg_state;

    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    logic [DW-1:0] ram    [0:MEMSZ-1] = '{default: '0};
    logic [DW-1:0] shadow [0:MEMSZ-1] = '{default: '0};

    always #5 clock = ~clock;

    ram_copy_engine #(.AW(AW), .DW(DW)) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode),
        .src(src), .dst(dst), .len(len), .fill_value(fill_value),
        .busy(busy), .done(done), .mem_address(mem_address), .mem_in(mem_in),
        .mem_load(mem_load), .mem_out(mem_out), .dbg_state(dbg_state)
    );

    // RAM16K-style memory: combinational read, write on posedge when load is high
    assign mem_out = ram[mem_address];
    always @(posedge clock) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        if (mem_load) ram[mem_address] <= mem_in;
    end

    // ---------------- reference model ----------------
    logic [AW+DW-1:0] exp_q[$];
    logic [DW-1:0]    pend [int];
    bit m_live = 0, m_active = 0, m_mode = 0;
    int m_k = 0, m_n = 0, m_src = 0, m_dst = 0;

    function automatic int last_cycle();
        if (m_n == 0) return 1;
        return m_mode ? m_n + 1 : 2 * m_n + 1;
    endfunction

    function automatic bit is_write_cyc(int k);
        if (m_n == 0) return 1'b0;
        if (m_mode) return k <= m_n;
        return (k <= 2 * m_n) && (k % 2 == 0);
    endfunction

    function automatic bit is_read_cyc(int k);
        return (m_n != 0) && !m_mode && (k <= 2 * m_n) && (k % 2 == 1);
    endfunction

    always @(posedge clock) begin
        logic [AW+DW-1:0] e;
        if (m_active && is_write_cyc(m_k) && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            shadow[e[AW+DW-1:DW]] = e[DW-1:0];
        end
        if (pre_we) shadow[pre_addr] = pre_data;
        if (reset) begin
            m_active = 0;
            m_k = 0;
            exp_q.delete();
            m_live = 1;
        end else if (m_active) begin
            if (m_k == last_cycle()) begin
                m_active = 0;
                m_k = 0;
            end else begin
                m_k++;
            end
        end else if (start) begin
            m_mode = mode;
            m_src = int'(src);
            m_dst = int'(dst);
            m_n = int'(len);
            m_k = 1;
            m_active = 1;
            pend.delete();
            // Ascending word-by-word semantics: a source word already overwritten reads back the new value
            for (int i = 0; i < m_n; i++) begin
                int sa, da;
                logic [DW-1:0] v;
                da = (m_dst + i) & MASK;
                sa = (m_src + i) & MASK;
                if (m_mode) v = fill_value;
                else v = pend.exists(sa) ? pend[sa] : shadow[sa];
                pend[da] = v;
                exp_q.push_back({AW'(da), v});
            end
        end
    end

    // ---------------- compare process ----------------
    int n_vec = 0, n_miss = 0;
    string       req_name = "";
    logic [31:0] req_act = '0, req_exp = '0;
    bit          req_tog = 0, req_ack = 0;

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        logic [AW+DW-1:0] e;
        bit eb, ed, el;
        if (req_tog != req_ack) begin
            cmp(req_name, req_act, req_exp);
            req_ack = req_tog;
        end
        if (m_live) begin
            eb = m_active && (m_n != 0) && (m_k < last_cycle());
            ed = m_active && (m_k == last_cycle());
            el = m_active && is_write_cyc(m_k);
            cmp("busy", 32'(busy), 32'(eb));
            cmp("done", 32'(done), 32'(ed));
            cmp("mem_load", 32'(mem_load), 32'(el));
            if (m_active && is_read_cyc(m_k))
                cmp("read_addr", 32'(mem_address), 32'((m_src + (m_k - 1) / 2) & MASK));
            if (el) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL write_expected @%0t: got write to %0h, want none", $time, mem_address);
                end else begin
                    e = exp_q[0];
                    cmp("write_addr", 32'(mem_address), 32'(e[AW+DW-1:DW]));
                    cmp("write_data", 32'(mem_in), 32'(e[DW-1:0]));
                end
            end
            if (ed) begin
                for (int i = 0; i < m_n; i++)
                    cmp("ram_vs_model", 32'(ram[(m_dst + i) & MASK]), 32'(shadow[(m_dst + i) & MASK]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        req_name = nm;
        req_act  = act;
        req_exp  = exp;
        req_tog  = ~req_tog;
        for (int i = 0; i < 4 && req_ack != req_tog; i++) @(negedge clock);
    endtask

    task automatic preload(input int a, input logic [DW-1:0] d);
        @(negedge clock);
        pre_we   = 1'b1;
        pre_addr = AW'(a);
        pre_data = d;
        @(negedge clock);
        pre_we   = 1'b0;
    endtask

    task automatic go(input bit md, input int s, input int d, input int l, input logic [DW-1:0] f);
        @(negedge clock);
        mode = md;
        src = AW'(s);
        dst = AW'(d);
        len = (AW+1)'(l);
        fill_value = f;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input bit noise, output int busy_cnt, output int load_cnt, output int done_cyc);
        busy_cnt = 0;
        load_cnt = 0;
        done_cyc = 0;
        for (int c = 1; c <= 40000; c++) begin
            if (busy) busy_cnt++;
            if (mem_load) load_cnt++;
            if (done) begin
                done_cyc = c;
                start = 1'b0;
                break;
            end
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                mode = 1'($urandom_range(0, 1));
                src = AW'($urandom_range(0, MASK));
                dst = AW'($urandom_range(0, MASK));
                len = (AW+1)'($urandom_range(0, 9));
                fill_value = DW'($urandom);
            end
            @(negedge clock);
        end
        start = 1'b0;
        chk("done_within_bound", 32'(done_cyc != 0), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int bc, lc, dc, ndone, s, d, l;
        repeat (2) @(negedge clock);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_load", 32'(mem_load), 32'd0);
        chk("reset_addr", 32'(mem_address), 32'd0);
        chk("reset_in", 32'(mem_in), 32'd0);
        reset = 1'b0;

        // copy basic
        preload(100, 16'h1111); preload(101, 16'h2222);
        preload(102, 16'h3333); preload(103, 16'h4444);
        preload(204, 16'h5A5A);
        go(1'b0, 100, 200, 4, 16'h0);
        wait_done(1'b0, bc, lc, dc);
        chk("copy_busy_cycles", 32'(bc), 32'd8);
        chk("copy_done_cycle", 32'(dc), 32'd9);
        chk("copy_w200", 32'(ram[200]), 32'h1111);
        chk("copy_w201", 32'(ram[201]), 32'h2222);
        chk("copy_w202", 32'(ram[202]), 32'h3333);
        chk("copy_w203", 32'(ram[203]), 32'h4444);
        chk("copy_w204_kept", 32'(ram[204]), 32'h5A5A);

        // fill with wrap
        preload(2, 16'h1234);
        go(1'b1, 0, 14'h3FFE, 4, 16'hBEEF);
        wait_done(1'b0, bc, lc, dc);
        chk("fill_busy_cycles", 32'(bc), 32'd4);
        chk("fill_load_cycles", 32'(lc), 32'd4);
        chk("fill_done_cycle", 32'(dc), 32'd5);
        chk("fill_3ffe", 32'(ram[14'h3FFE]), 32'hBEEF);
        chk("fill_3fff", 32'(ram[14'h3FFF]), 32'hBEEF);
        chk("fill_0000", 32'(ram[0]), 32'hBEEF);
        chk("fill_0001", 32'(ram[1]), 32'hBEEF);
        chk("fill_0002_kept", 32'(ram[2]), 32'h1234);

        // zero length
        go(1'b0, 5, 6, 0, 16'h0);
        wait_done(1'b0, bc, lc, dc);
        chk("zero_busy_cycles", 32'(bc), 32'd0);
        chk("zero_load_cycles", 32'(lc), 32'd0);
        chk("zero_done_cycle", 32'(dc), 32'd1);

        // overlapping forward copy
        for (int i = 0; i < 4; i++) preload(10 + i, DW'(i + 1));
        go(1'b0, 10, 11, 3, 16'h0);
        wait_done(1'b0, bc, lc, dc);
        for (int i = 0; i < 4; i++) chk("overlap", 32'(ram[10 + i]), 32'd1);

        // dst == src: unchanged contents, full copy timing
        go(1'b0, 100, 100, 4, 16'h0);
        wait_done(1'b0, bc, lc, dc);
        chk("self_busy_cycles", 32'(bc), 32'd8);
        chk("self_w103", 32'(ram[103]), 32'h4444);

        // start while busy and in DONE is ignored
        for (int i = 0; i < 4; i++) preload(300 + i, DW'(16'hC000 + i));
        preload(500, 16'h0A0A);
        go(1'b0, 300, 400, 4, 16'h0);
        @(negedge clock);
        mode = 1'b1; dst = 14'd500; len = 15'd2; fill_value = 16'hFFFF; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int c = 0; c < 20 && !done; c++) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            if (done) ndone++;
            @(negedge clock);
        end
        chk("ignored_start_done_pulses", 32'(ndone), 32'd0);
        chk("ignored_start_500", 32'(ram[500]), 32'h0A0A);
        chk("busy_copy_403", 32'(ram[403]), 32'hC003);

        // reset mid-copy: reset sampled at the edge that would enter the 3rd WRITE
        for (int i = 0; i < 8; i++) preload(600 + i, DW'(16'h6000 + i));
        for (int i = 0; i < 8; i++) preload(700 + i, 16'hDEAD);
        go(1'b0, 600, 700, 8, 16'h0);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_load", 32'(mem_load), 32'd0);
        chk("abort_w700", 32'(ram[700]), 32'h6000);
        chk("abort_w701", 32'(ram[701]), 32'h6001);
        chk("abort_w702_kept", 32'(ram[702]), 32'hDEAD);
        go(1'b0, 600, 800, 2, 16'h0);
        wait_done(1'b0, bc, lc, dc);
        chk("after_abort_w801", 32'(ram[801]), 32'h6001);

        // randomized transfers with noise on the inputs while busy
        for (int t = 0; t < 14; t++) begin
            s = $urandom_range(0, MASK);
            d = ($urandom_range(0, 3) == 0) ? ((s + $urandom_range(0, 3)) & MASK) : $urandom_range(0, MASK);
            l = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(1, 24);
            for (int i = 0; i < 3; i++) preload((s + i) & MASK, DW'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clock);
            go(1'($urandom_range(0, 1)), s, d, l, DW'($urandom));
            wait_done(1'b1, bc, lc, dc);
        end

        // full-size fill touches every word once
        go(1'b1, 0, $urandom_range(0, MASK), MEMSZ, 16'h7E57);
        wait_done(1'b0, bc, lc, dc);
        chk("full_fill_loads", 32'(lc), 32'(MEMSZ));
        chk("full_fill_w0", 32'(ram[0]), 32'h7E57);

        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ram_copy_engine.md
Name: ram_copy_engine

Overview:
- Memory-side initiator that drives the single-port word RAM interface used by the RAM8…RAM16K family: in, load, address, out.
- Read data is combinational from address; writes commit on the posedge when load is high.
- Performs block copy (src→dst) or block fill (constant→dst) of len words under a start/busy/done handshake.
- Sits between a control unit (or testbench) and a RAM16K-class memory; replaces hand-sequenced load/address toggling.

Parameters:
- AW, 14, RAM address width (RAM16K default).
- DW, 16, data word width.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- mode  input  1  0 = copy, 1 = fill; sampled with start.
- src  input  AW  copy source base address; sampled with start.
- dst  input  AW  destination base address; sampled with start.
- len  input  AW+1  word count, 0..2^AW; sampled with start.
- fill_value  input  DW  fill word; sampled with start.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle completion pulse.
- mem_address  output  AW  to RAM address.
- mem_in  output  DW  to RAM in.
- mem_load  output  1  to RAM load.
- mem_out  input  DW  from RAM out (combinational read).

Behaviour:
- Reset (synchronous): state IDLE; busy=0, done=0, mem_load=0, mem_address=0, mem_in=0; internal pointers, count and data latch cleared. Reset mid-transfer aborts at that edge: no further writes, and no done pulse.
- States: IDLE, READ, WRITE, DONE. All outputs are decoded from registered state and registers only, never combinationally from start.
- IDLE:
  - On an edge with start=1, latch mode, src, dst, len and fill_value, then set count=len.
  - If len=0, go to DONE and perform no memory access.
  - Otherwise go to READ (copy) or WRITE (fill).
  - mem_load=0 in IDLE.
- READ (copy only):
  - mem_address=src_ptr, mem_load=0.
  - At the edge, data latch ← mem_out; go to WRITE.
- WRITE:
  - mem_address=dst_ptr, mem_in=data latch (copy) or fill_value (fill), mem_load=1.
  - At the edge, dst_ptr+1 and src_ptr+1 (copy), count−1.
  - If count was 1, go to DONE; else go to READ (copy) or stay in WRITE (fill).
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. start in the DONE cycle is ignored.
- busy=1 in READ and WRITE only. start while busy is ignored; inputs may change freely while busy.
- Latency:
  - Copy of N≥1 words: busy for 2N cycles; done in cycle 2N+1 after the start edge.
  - Fill of N words: busy for N cycles; done in cycle N+1.
  - len=0: done in the cycle after the start edge, with busy never asserted.
- Address arithmetic is modulo 2^AW: pointers wrap from 2^AW−1 to 0.
- len=2^AW is legal and touches every word once.
- Overlap: the copy is strictly ascending, one word read then written.
  - If dst is in (src, src+len), source words are overwritten before being read. The result is the defined forward-propagation pattern, not memmove.
  - If dst=src, the memory is unchanged but the full timing still applies.
- Only one RAM access per cycle; the engine never asserts mem_load in READ, IDLE or DONE.

Test Plan:
- Copy basic: preload RAM[100..103]=0x1111,0x2222,0x3333,0x4444; start mode=0 src=100 dst=200 len=4 → busy 8 cycles; done pulse 1 cycle; RAM[200..203] equal the source words; RAM[204] unchanged.
- Fill with wrap: start mode=1 dst=0x3FFE len=4 fill_value=0xBEEF → writes to 0x3FFE, 0x3FFF, 0x0000, 0x0001 in 4 consecutive cycles with mem_load=1; done at cycle 5.
- Zero length: start len=0 → busy never 1; done=1 in the next cycle; mem_load stays 0 throughout.
- Overlap forward: RAM[10..13]=1,2,3,4; copy src=10 dst=11 len=3 → RAM[10..13]=1,1,1,1.
- Start while busy / in DONE: second start pulses during a 4-word copy and in its DONE cycle → ignored; exactly one done pulse; only the first transfer's writes occur.
- Reset mid-copy: assert reset on the 3rd WRITE cycle of a len=8 copy → from the next cycle busy=0, done=0, mem_load=0; only the first 2 destination words are written; a new start afterwards completes normally.
